tl_a_rr_arbiter: RTL and testbench

- Two-client TileLink-UL crossbar front-end that shares one buffered A/D link toward a single manager.
- Round-robin arbitration on channel A, with burst locking so multi-beat PutFullData/PutPartialData messages are never interleaved.
- Client index is prepended to the source ID on A; D responses are routed back by that source bit.
- Sits directly upstream of the A/D buffer stage feeding the 13-bit-address peripheral fabric.

---
 rtl/tl_pkg.sv | 60 ++++++
 rtl/tl_rr_grant.sv | 70 +++++++
 rtl/tl_a_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tl_a_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// TileLink-UL shared types and constants for the A/D arbiter slice.
// Holds bundle structs and the message beat-count helper.
package tl_pkg;

  localparam int SRC_BITS       = 5;
  localparam int ADDR_BITS      = 13;
  localparam int BEAT_BYTES_LOG = 3;
  localparam int MAX_SIZE       = 6;
  localparam int DATA_BITS      = 64;
  localparam int MASK_BITS      = 8;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef enum logic {
    IDLE,
    LOCKED
  } mode_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [2:0]           size;
    logic [SRC_BITS:0]    source;
    logic [ADDR_BITS-1:0] address;
    logic [MASK_BITS-1:0] mask;
    logic [DATA_BITS-1:0] data;
    logic                 corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [2:0]           size;
    logic [SRC_BITS:0]    source;
    logic                 sink;
    logic                 denied;
    logic [DATA_BITS-1:0] data;
    logic                 corrupt;
  } tl_d_t;

  // Oversized requests saturate to the largest legal burst.
  function automatic logic [3:0] num_beats(
    input logic [2:0] opcode,
    input logic [2:0] size
  );
    logic [2:0] sz;
    logic [3:0] b;
    sz = (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
    b  = 4'd1;
    if ((opcode == PUT_FULL || opcode == PUT_PARTIAL) &&
        sz > 3'(BEAT_BYTES_LOG))
      b = 4'd1 << (sz - 3'(BEAT_BYTES_LOG));
    return b;
  endfunction

endpackage

// File: rtl/tl_rr_grant.sv
// Two-way round-robin picker with burst lock.
// Holds the rr/lock state; the grant itself is combinational.
module tl_rr_grant
  import tl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       fire,
  input  logic [3:0] beats,
  output logic       grant
);

  mode_t      mode, mode_nx;
  logic       lock_id, lock_id_nx;
  logic [2:0] beats_left, beats_left_nx;
  logic       rr_last, rr_last_nx;

  // Pick a client: lock owner while locked, else round-robin.
  always_comb begin
    grant = 1'b0;
    if (mode == LOCKED) begin
      grant = lock_id;
    end else begin
      unique case (1'b1)
        (req == 2'b11): grant = ~rr_last;
        (req == 2'b10): grant = 1'b1;
        default:        grant = 1'b0;
      endcase
    end
  end

  // Next state: open a lock on multi-beat fires, count it down.
  always_comb begin
    mode_nx       = mode;
    lock_id_nx    = lock_id;
    beats_left_nx = beats_left;
    rr_last_nx    = rr_last;
    if (fire) begin
      if (mode == IDLE) begin
        rr_last_nx = grant;
        if (beats > 4'd1) begin
          mode_nx       = LOCKED;
          lock_id_nx    = grant;
          beats_left_nx = 3'(beats - 4'd1);
        end
      end else begin
        beats_left_nx = beats_left - 3'd1;
        if (beats_left == 3'd1)
          mode_nx = IDLE;
      end
    end
  end

  // State register; reset favours client 0 in the first contest.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode       <= IDLE;
      lock_id    <= 1'b0;
      beats_left <= 3'd0;
      rr_last    <= 1'b1;
    end else begin
      mode       <= mode_nx;
      lock_id    <= lock_id_nx;
      beats_left <= beats_left_nx;
      rr_last    <= rr_last_nx;
    end
  end

endmodule

// File: rtl/tl_a_rr_arbiter.sv
// Two-client TileLink-UL front-end sharing one A/D link.
// A is arbitrated with burst lock; D is routed by source MSB.
module tl_a_rr_arbiter
  import tl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  output logic                 in0_a_ready,
  input  logic                 in0_a_valid,
  input  logic [2:0]           in0_a_bits_opcode,
  input  logic [2:0]           in0_a_bits_param,
  input  logic [2:0]           in0_a_bits_size,
  input  logic [SRC_BITS-1:0]  in0_a_bits_source,
  input  logic [ADDR_BITS-1:0] in0_a_bits_address,
  input  logic [7:0]           in0_a_bits_mask,
  input  logic [63:0]          in0_a_bits_data,
  input  logic                 in0_a_bits_corrupt,
  output logic                 in1_a_ready,
  input  logic                 in1_a_valid,
  input  logic [2:0]           in1_a_bits_opcode,
  input  logic [2:0]           in1_a_bits_param,
  input  logic [2:0]           in1_a_bits_size,
  input  logic [SRC_BITS-1:0]  in1_a_bits_source,
  input  logic [ADDR_BITS-1:0] in1_a_bits_address,
  input  logic [7:0]           in1_a_bits_mask,
  input  logic [63:0]          in1_a_bits_data,
  input  logic                 in1_a_bits_corrupt,
  input  logic                 out_a_ready,
  output logic                 out_a_valid,
  output logic [2:0]           out_a_bits_opcode,
  output logic [2:0]           out_a_bits_param,
  output logic [2:0]           out_a_bits_size,
  output logic [SRC_BITS:0]    out_a_bits_source,
  output logic [ADDR_BITS-1:0] out_a_bits_address,
  output logic [7:0]           out_a_bits_mask,
  output logic [63:0]          out_a_bits_data,
  output logic                 out_a_bits_corrupt,
  output logic                 out_d_ready,
  input  logic                 out_d_valid,
  input  logic [2:0]           out_d_bits_opcode,
  input  logic [1:0]           out_d_bits_param,
  input  logic [2:0]           out_d_bits_size,
  input  logic [SRC_BITS:0]    out_d_bits_source,
  input  logic                 out_d_bits_sink,
  input  logic                 out_d_bits_denied,
  input  logic [63:0]          out_d_bits_data,
  input  logic                 out_d_bits_corrupt,
  input  logic                 in0_d_ready,
  output logic                 in0_d_valid,
  output logic [2:0]           in0_d_bits_opcode,
  output logic [1:0]           in0_d_bits_param,
  output logic [2:0]           in0_d_bits_size,
  output logic [SRC_BITS-1:0]  in0_d_bits_source,
  output logic                 in0_d_bits_sink,
  output logic                 in0_d_bits_denied,
  output logic [63:0]          in0_d_bits_data,
  output logic                 in0_d_bits_corrupt,
  input  logic                 in1_d_ready,
  output logic                 in1_d_valid,
  output logic [2:0]           in1_d_bits_opcode,
  output logic [1:0]           in1_d_bits_param,
  output logic [2:0]           in1_d_bits_size,
  output logic [SRC_BITS-1:0]  in1_d_bits_source,
  output logic                 in1_d_bits_sink,
  output logic                 in1_d_bits_denied,
  output logic [63:0]          in1_d_bits_data,
  output logic                 in1_d_bits_corrupt
);

  tl_a_t a0, a1, a_sel;
  tl_d_t d;
  logic  grant;
  logic  fire;
  logic  d_sel;

  assign a0 = '{
    opcode:  in0_a_bits_opcode,
    param:   in0_a_bits_param,
    size:    in0_a_bits_size,
    source:  {1'b0, in0_a_bits_source},
    address: in0_a_bits_address,
    mask:    in0_a_bits_mask,
    data:    in0_a_bits_data,
    corrupt: in0_a_bits_corrupt
  };

  assign a1 = '{
    opcode:  in1_a_bits_opcode,
    param:   in1_a_bits_param,
    size:    in1_a_bits_size,
    source:  {1'b1, in1_a_bits_source},
    address: in1_a_bits_address,
    mask:    in1_a_bits_mask,
    data:    in1_a_bits_data,
    corrupt: in1_a_bits_corrupt
  };

  assign a_sel = grant ? a1 : a0;
  assign fire  = out_a_valid & out_a_ready;

  tl_rr_grant u_grant (
    .clock (clock),
    .reset (reset),
    .req   ({in1_a_valid, in0_a_valid}),
    .fire  (fire),
    .beats (num_beats(a_sel.opcode, a_sel.size)),
    .grant (grant)
  );

  // A mux: forward the granted client, block the other.
  always_comb begin
    out_a_valid        = grant ? in1_a_valid : in0_a_valid;
    out_a_bits_opcode  = a_sel.opcode;
    out_a_bits_param   = a_sel.param;
    out_a_bits_size    = a_sel.size;
    out_a_bits_source  = a_sel.source;
    out_a_bits_address = a_sel.address;
    out_a_bits_mask    = a_sel.mask;
    out_a_bits_data    = a_sel.data;
    out_a_bits_corrupt = a_sel.corrupt;
    in0_a_ready        = ~grant & in0_a_valid & out_a_ready;
    in1_a_ready        = grant & in1_a_valid & out_a_ready;
  end

  assign d = '{
    opcode:  out_d_bits_opcode,
    param:   out_d_bits_param,
    size:    out_d_bits_size,
    source:  out_d_bits_source,
    sink:    out_d_bits_sink,
    denied:  out_d_bits_denied,
    data:    out_d_bits_data,
    corrupt: out_d_bits_corrupt
  };

  assign d_sel = d.source[SRC_BITS];

  // D demux: steer by the client bit, strip it from source.
  always_comb begin
    out_d_ready        = d_sel ? in1_d_ready : in0_d_ready;
    in0_d_valid        = out_d_valid & ~d_sel;
    in1_d_valid        = out_d_valid & d_sel;
    in0_d_bits_opcode  = d.opcode;
    in0_d_bits_param   = d.param;
    in0_d_bits_size    = d.size;
    in0_d_bits_source  = d.source[SRC_BITS-1:0];
    in0_d_bits_sink    = d.sink;
    in0_d_bits_denied  = d.denied;
    in0_d_bits_data    = d.data;
    in0_d_bits_corrupt = d.corrupt;
    in1_d_bits_opcode  = d.opcode;
    in1_d_bits_param   = d.param;
    in1_d_bits_size    = d.size;
    in1_d_bits_source  = d.source[SRC_BITS-1:0];
    in1_d_bits_sink    = d.sink;
    in1_d_bits_denied  = d.denied;
    in1_d_bits_data    = d.data;
    in1_d_bits_corrupt = d.corrupt;
  end

endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// Directed bench for tl_a_rr_arbiter.
// Table vectors plus hand sequences for burst/reset cases.
module tb_tl_a_rr_arbiter;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in0_a_ready, in0_a_valid;
  logic [2:0]  in0_a_op, in0_a_param, in0_a_size;
  logic [4:0]  in0_a_src;
  logic [12:0] in0_a_addr;
  logic [7:0]  in0_a_mask;
  logic [63:0] in0_a_data;
  logic        in0_a_corrupt;
  logic        in1_a_ready, in1_a_valid;
  logic [2:0]  in1_a_op, in1_a_param, in1_a_size;
  logic [4:0]  in1_a_src;
  logic [12:0] in1_a_addr;
  logic [7:0]  in1_a_mask;
  logic [63:0] in1_a_data;
  logic        in1_a_corrupt;
  logic        out_a_ready, out_a_valid;
  logic [2:0]  out_a_op, out_a_param, out_a_size;
  logic [5:0]  out_a_src;
  logic [12:0] out_a_addr;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_ready, out_d_valid;
  logic [2:0]  out_d_op, out_d_size;
  logic [1:0]  out_d_param;
  logic [5:0]  out_d_src;
  logic        out_d_sink, out_d_denied, out_d_corrupt;
  logic [63:0] out_d_data;
  logic        in0_d_ready, in0_d_valid;
  logic [2:0]  in0_d_op, in0_d_size;
  logic [1:0]  in0_d_param;
  logic [4:0]  in0_d_src;
  logic        in0_d_sink, in0_d_denied, in0_d_corrupt;
  logic [63:0] in0_d_data;
  logic        in1_d_ready, in1_d_valid;
  logic [2:0]  in1_d_op, in1_d_size;
  logic [1:0]  in1_d_param;
  logic [4:0]  in1_d_src;
  logic        in1_d_sink, in1_d_denied, in1_d_corrupt;
  logic [63:0] in1_d_data;

  tl_a_rr_arbiter dut (
    .clock(clk), .reset(reset),
    .in0_a_ready(in0_a_ready), .in0_a_valid(in0_a_valid),
    .in0_a_bits_opcode(in0_a_op), .in0_a_bits_param(in0_a_param),
    .in0_a_bits_size(in0_a_size), .in0_a_bits_source(in0_a_src),
    .in0_a_bits_address(in0_a_addr), .in0_a_bits_mask(in0_a_mask),
    .in0_a_bits_data(in0_a_data), .in0_a_bits_corrupt(in0_a_corrupt),
    .in1_a_ready(in1_a_ready), .in1_a_valid(in1_a_valid),
    .in1_a_bits_opcode(in1_a_op), .in1_a_bits_param(in1_a_param),
    .in1_a_bits_size(in1_a_size), .in1_a_bits_source(in1_a_src),
    .in1_a_bits_address(in1_a_addr), .in1_a_bits_mask(in1_a_mask),
    .in1_a_bits_data(in1_a_data), .in1_a_bits_corrupt(in1_a_corrupt),
    .out_a_ready(out_a_ready), .out_a_valid(out_a_valid),
    .out_a_bits_opcode(out_a_op), .out_a_bits_param(out_a_param),
    .out_a_bits_size(out_a_size), .out_a_bits_source(out_a_src),
    .out_a_bits_address(out_a_addr), .out_a_bits_mask(out_a_mask),
    .out_a_bits_data(out_a_data), .out_a_bits_corrupt(out_a_corrupt),
    .out_d_ready(out_d_ready), .out_d_valid(out_d_valid),
    .out_d_bits_opcode(out_d_op), .out_d_bits_param(out_d_param),
    .out_d_bits_size(out_d_size), .out_d_bits_source(out_d_src),
    .out_d_bits_sink(out_d_sink), .out_d_bits_denied(out_d_denied),
    .out_d_bits_data(out_d_data), .out_d_bits_corrupt(out_d_corrupt),
    .in0_d_ready(in0_d_ready), .in0_d_valid(in0_d_valid),
    .in0_d_bits_opcode(in0_d_op), .in0_d_bits_param(in0_d_param),
    .in0_d_bits_size(in0_d_size), .in0_d_bits_source(in0_d_src),
    .in0_d_bits_sink(in0_d_sink), .in0_d_bits_denied(in0_d_denied),
    .in0_d_bits_data(in0_d_data), .in0_d_bits_corrupt(in0_d_corrupt),
    .in1_d_ready(in1_d_ready), .in1_d_valid(in1_d_valid),
    .in1_d_bits_opcode(in1_d_op), .in1_d_bits_param(in1_d_param),
    .in1_d_bits_size(in1_d_size), .in1_d_bits_source(in1_d_src),
    .in1_d_bits_sink(in1_d_sink), .in1_d_bits_denied(in1_d_denied),
    .in1_d_bits_data(in1_d_data), .in1_d_bits_corrupt(in1_d_corrupt)
  );

  typedef struct {
    string      nm;
    logic       v0, v1;
    logic [2:0] op0, sz0;
    logic [4:0] s0;
    logic [2:0] op1, sz1;
    logic [4:0] s1;
    logic       ar, dv;
    logic [5:0] ds;
    logic       dr0, dr1;
    logic       e_av;
    logic [5:0] e_as;
    logic       e_r0, e_r1, e_dv0, e_dv1, e_dr;
    logic [4:0] e_ds;
  } vec_t;

  vec_t vec [10];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in0_a_valid = 1'b0;
    in1_a_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // in1 opens a message while in0 waits; count in1 grants.
  task automatic run_burst(input string nm, input logic [2:0] op,
                           input logic [2:0] sz, input int exp);
    int cnt;
    cnt = 0;
    @(negedge clk);
    out_a_ready = 1'b1;
    in0_a_op = GET; in0_a_size = 3'd3;
    in1_a_op = op;  in1_a_size = sz;
    in1_a_valid = 1'b1;
    in0_a_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(negedge clk);
        in0_a_valid = 1'b1;
      end
      #1;
      if (out_a_src[5]) cnt++;
      else break;
    end
    chk(nm, 64'(cnt), 64'(exp));
    @(negedge clk);
    in0_a_valid = 1'b0;
    in1_a_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in0_a_valid = 0; in0_a_op = GET; in0_a_param = 0; in0_a_size = 3;
    in0_a_src = 0; in0_a_addr = 13'h100; in0_a_mask = 8'hff;
    in0_a_data = 0; in0_a_corrupt = 0;
    in1_a_valid = 0; in1_a_op = GET; in1_a_param = 0; in1_a_size = 3;
    in1_a_src = 0; in1_a_addr = 13'h200; in1_a_mask = 8'hff;
    in1_a_data = 0; in1_a_corrupt = 0;
    out_a_ready = 0;
    out_d_valid = 0; out_d_op = ACK_DATA; out_d_param = 0;
    out_d_size = 3; out_d_src = 0; out_d_sink = 0; out_d_denied = 0;
    out_d_data = 64'h1234; out_d_corrupt = 0;
    in0_d_ready = 0; in1_d_ready = 0;

    vec[0] = '{"idle", 0,0, GET,3,0, GET,3,0, 1, 0,6'h00,1,0,
               0,6'h00, 0,0, 0,0,1, 5'h00};
    vec[1] = '{"single0_d1", 1,0, GET,3,5, GET,3,0, 1, 1,6'h23,1,0,
               1,6'h05, 1,0, 0,1,0, 5'h03};
    vec[2] = '{"rr_a", 1,1, GET,3,1, GET,3,2, 1, 0,6'h00,1,0,
               1,6'h22, 0,1, 0,0,1, 5'h00};
    vec[3] = '{"rr_b", 1,1, GET,3,1, GET,3,2, 1, 0,6'h00,1,0,
               1,6'h01, 1,0, 0,0,1, 5'h00};
    vec[4] = '{"rr_c", 1,1, GET,3,1, GET,3,2, 1, 0,6'h00,1,0,
               1,6'h22, 0,1, 0,0,1, 5'h00};
    vec[5] = '{"rr_d", 1,1, GET,3,1, GET,3,2, 1, 0,6'h00,1,0,
               1,6'h01, 1,0, 0,0,1, 5'h00};
    vec[6] = '{"stall", 1,1, GET,3,1, GET,3,2, 0, 0,6'h00,1,0,
               1,6'h22, 0,0, 0,0,1, 5'h00};
    vec[7] = '{"stall1_d0", 0,1, GET,3,1, PUT_FULL,6,2, 0, 1,6'h1f,1,0,
               1,6'h22, 0,0, 1,0,1, 5'h1f};
    vec[8] = '{"idle_d1", 0,0, GET,3,10, GET,3,2, 1, 1,6'h3f,0,1,
               0,6'h0a, 0,0, 0,1,1, 5'h1f};
    vec[9] = '{"single1", 0,1, GET,3,10, GET,3,17, 1, 0,6'h00,0,1,
               1,6'h31, 0,1, 0,0,0, 5'h00};

    do_reset();
    #1;
    chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_in1_a_ready", 64'(in1_a_ready), 64'd0);
    chk("rst_beats_left", 64'(dut.u_grant.beats_left), 64'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in0_a_valid = vec[i].v0; in0_a_op = vec[i].op0;
      in0_a_size = vec[i].sz0; in0_a_src = vec[i].s0;
      in1_a_valid = vec[i].v1; in1_a_op = vec[i].op1;
      in1_a_size = vec[i].sz1; in1_a_src = vec[i].s1;
      out_a_ready = vec[i].ar;
      out_d_valid = vec[i].dv; out_d_src = vec[i].ds;
      in0_d_ready = vec[i].dr0; in1_d_ready = vec[i].dr1;
      #1;
      chk(vec[i].nm,
          {out_a_valid, out_a_src, in0_a_ready, in1_a_ready,
           in0_d_valid, in1_d_valid, out_d_ready, in0_d_src, in1_d_src},
          {vec[i].e_av, vec[i].e_as, vec[i].e_r0, vec[i].e_r1,
           vec[i].e_dv0, vec[i].e_dv1, vec[i].e_dr,
           vec[i].e_ds, vec[i].e_ds});
    end
    out_d_valid = 1'b0;

    do_reset();
    in0_a_op = GET; in1_a_op = GET;
    in0_a_size = 3; in1_a_size = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in0_a_valid = 1; in1_a_valid = 1; out_a_ready = 1;
      #1;
      chk($sformatf("contend_%0d", i), 64'(out_a_src[5]), 64'(i % 2));
    end

    do_reset();
    in1_a_op = PUT_FULL; in1_a_size = 6;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      in1_a_valid = 1; in0_a_valid = (b > 0); out_a_ready = 1;
      in1_a_data = 64'(b);
      #1;
      chk($sformatf("burst_g%0d", b), 64'(out_a_src[5]), 64'd1);
      chk($sformatf("burst_d%0d", b), out_a_data, 64'(b));
      chk($sformatf("burst_r0_%0d", b), 64'(in0_a_ready), 64'd0);
    end
    @(negedge clk);
    #1;
    chk("burst_after_g", 64'(out_a_src[5]), 64'd0);
    chk("burst_after_r0", 64'(in0_a_ready), 64'd1);

    do_reset();
    in1_a_op = PUT_FULL; in1_a_size = 6;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      in1_a_valid = 1; in0_a_valid = (b > 0); out_a_ready = 1;
      in1_a_data = 64'(b);
      #1;
      chk($sformatf("bp_d%0d", b), out_a_data, 64'(b));
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      out_a_ready = 0; in1_a_data = 64'd99;
      #1;
      chk($sformatf("bp_hold_%0d", h),
          64'(dut.u_grant.beats_left), 64'd4);
      chk($sformatf("bp_r1_%0d", h), 64'(in1_a_ready), 64'd0);
    end
    @(negedge clk);
    in1_a_valid = 0; out_a_ready = 1;
    #1;
    chk("vlow_out_valid", 64'(out_a_valid), 64'd0);
    chk("vlow_r0", 64'(in0_a_ready), 64'd0);
    for (int b = 4; b < 8; b++) begin
      @(negedge clk);
      in1_a_valid = 1; in1_a_data = 64'(b);
      #1;
      chk($sformatf("bp_d%0d", b),
          {out_a_src[5], out_a_data}, {1'b1, 64'(b)});
    end
    @(negedge clk);
    #1;
    chk("bp_after_g", 64'(out_a_src[5]), 64'd0);

    do_reset();
    in1_a_op = PUT_FULL; in1_a_size = 6;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      in1_a_valid = 1; in0_a_valid = 0; out_a_ready = 1;
    end
    @(negedge clk);
    reset = 1; in1_a_valid = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rstmid_mode", 64'(dut.u_grant.mode == IDLE), 64'd1);
    chk("rstmid_beats", 64'(dut.u_grant.beats_left), 64'd0);
    in0_a_valid = 1; in1_a_valid = 1; in1_a_op = GET; in1_a_size = 3;
    #1;
    chk("rstmid_grant", 64'(out_a_src[5]), 64'd0);
    @(negedge clk);
    in0_a_valid = 0; in1_a_valid = 0;

    run_burst("rb_put8", PUT_FULL, 3'd6, 8);
    run_burst("rb_oversize", PUT_FULL, 3'd7, 8);
    run_burst("rb_partial2", PUT_PARTIAL, 3'd4, 2);
    run_burst("rb_get_big", GET, 3'd6, 1);
    run_burst("rb_put_one", PUT_FULL, 3'd3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
